// File: rtl/parking_fee_calc.sv
// parking_fee_calc: sequential shift-add parking fee with free units and a saturating cap
module parking_fee_calc #(
  parameter logic [7:0]  FREE_UNITS = 8'd2,
  parameter logic [15:0] FEE_CAP    = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  time_total,
  input  logic [7:0]  rate,
  output logic        busy,
  output logic        done,
  output logic [15:0] fee
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  rate_q, rate_d, bill_q, bill_d;
  logic [15:0] acc_q, acc_d, fee_q, fee_d, acc_next;
  logic [2:0]  step_q, step_d;
  logic        done_q, done_d;
  // state and datapath registers; reset aborts any calculation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rate_q  <= 8'd0;
      bill_q  <= 8'd0;
      acc_q   <= 16'd0;
      step_q  <= 3'd0;
      fee_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      bill_q  <= bill_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      fee_q   <= fee_d;
      done_q  <= done_d;
    end
  end
  // next state: capture in IDLE, one multiplier bit per MUL cycle, saturate on the last step
  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    bill_d   = bill_q;
    acc_d    = acc_q;
    step_d   = step_q;
    fee_d    = fee_q;
    done_d   = done_q;
    acc_next = acc_q + (bill_q[step_q] ? ({8'd0, rate_q} << step_q) : 16'd0);
    case (state_q)
      IDLE: if (start) begin
        rate_d  = rate;
        bill_d  = (time_total > FREE_UNITS) ? time_total - FREE_UNITS : 8'd0;
        acc_d   = 16'd0;
        step_d  = 3'd0;
        state_d = MUL;
      end
      MUL: begin
        acc_d  = acc_next;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          fee_d   = (acc_next > FEE_CAP) ? FEE_CAP : acc_next;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign fee  = fee_q;
endmodule
